// File: rtl/or_reduce_arbiter.sv
// Two requesters share one external 2-input OR gate, granted round-robin.
// The owner's word is folded into the accumulator one bit per cycle, LSB first.
module or_reduce_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] in0,
    input  logic             req1,
    input  logic [WIDTH-1:0] in1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             result,
    output logic             result_valid,
    output logic             busy,
    output logic             or_a,
    output logic             or_b,
    input  logic             or_out
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        owner_d      = owner_q;
        last_d       = last_q;
        or_a         = 1'b0;
        or_b         = 1'b0;
        result       = 1'b0;
        result_valid = 1'b0;
        ack0         = 1'b0;
        ack1         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last wins.
                    owner_d = (req0 && req1) ? ~last_q : req1;
                    shift_d = owner_d ? in1 : in0;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                or_a    = acc_q;
                or_b    = shift_q[0];
                acc_d   = or_out;
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                result       = acc_q;
                result_valid = 1'b1;
                ack0         = ~owner_q;
                ack1         = owner_q;
                last_d       = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign gnt0 = busy & ~owner_q;
    assign gnt1 = busy & owner_q;

endmodule

// File: tb/tb_or_reduce_arbiter.sv
// Drives directed and random traffic into or_reduce_arbiter, closing the loop
// with a behavioural OR gate, and checks every output each cycle.
module tb_or_reduce_arbiter;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, req0, req1;
    logic [W-1:0] in0, in1;
    logic         gnt0, gnt1, ack0, ack1, result, result_valid, busy, or_a, or_b, or_out;

    always #5 clk = ~clk;
    assign or_out = or_a | or_b;

    or_reduce_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .in0(in0), .req1(req1), .in1(in1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .result(result), .result_valid(result_valid), .busy(busy),
        .or_a(or_a), .or_b(or_b), .or_out(or_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: an operation is "granted word, k cycles since grant".
    // k<W is a RUN cycle processing bit k, k==W is the completion cycle.
    bit         m_busy  = 1'b0;
    bit         m_owner = 1'b0;
    bit         m_last  = 1'b1;
    logic [W-1:0] m_word = '0;
    int         m_k     = 0;

    task automatic model_edge(input bit r, input bit q0, input bit q1,
                              input logic [W-1:0] w0, input logic [W-1:0] w1);
        if (r) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (!m_busy) begin
            if (q0 || q1) begin
                m_owner = (q0 && q1) ? !m_last : q1;
                m_word  = m_owner ? w1 : w0;
                m_busy  = 1'b1;
                m_k     = 0;
            end
        end else if (m_k == W) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end else begin
            m_k++;
        end
    endtask

    task automatic check_outputs();
        bit           done_c, run_c, exp_a;
        logic [W-1:0] mask;
        done_c = m_busy && (m_k == W);
        run_c  = m_busy && (m_k < W);
        mask   = (W'(1) << m_k) - W'(1);
        exp_a  = run_c && ((m_word & mask) != '0);
        chk("busy",   32'(busy),   32'(m_busy));
        chk("gnt0",   32'(gnt0),   32'(m_busy && !m_owner));
        chk("gnt1",   32'(gnt1),   32'(m_busy && m_owner));
        chk("gnt_excl", 32'(gnt0 & gnt1), 32'(0));
        chk("rvalid", 32'(result_valid), 32'(done_c));
        chk("ack0",   32'(ack0),   32'(done_c && !m_owner));
        chk("ack1",   32'(ack1),   32'(done_c && m_owner));
        chk("result", 32'(result), 32'(done_c && (m_word != '0)));
        chk("or_b",   32'(or_b),   32'(run_c && m_word[m_k % W]));
        chk("or_a",   32'(or_a),   32'(exp_a));
    endtask

    bit rec = 1'b0;
    int own_q[$], res_q[$], rv_q[$];
    int gnt0_cycles = 0;

    task automatic step(input bit r, input bit q0, input bit q1,
                        input logic [W-1:0] w0, input logic [W-1:0] w1);
        reset = r; req0 = q0; req1 = q1; in0 = w0; in1 = w1;
        @(posedge clk);
        model_edge(r, q0, q1, w0, w1);
        cyc++;
        @(negedge clk);
        check_outputs();
        if (gnt0) gnt0_cycles++;
        if (rec && result_valid) begin
            own_q.push_back(int'(ack1));
            res_q.push_back(int'(result));
            rv_q.push_back(cyc);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return W'(1) << $urandom_range(0, W - 1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; in0 = '0; in1 = '0;

        // Reset state
        step(1, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);

        // Zero word on requester 0: 17 granted cycles, result 0
        gnt0_cycles = 0;
        step(0, 1, 0, 16'h0000, '0);
        for (int i = 0; i < 18; i++) step(0, 0, 0, 16'hFFFF, '0);
        chk("gnt0_len", 32'(gnt0_cycles), 32'(17));

        // MSB-only word on requester 1
        step(1, 0, 0, '0, '0);
        step(0, 0, 1, '0, 16'h8000);
        for (int i = 0; i < 18; i++) step(0, 0, 0, '0, '0);

        // 0x0005: or_b/or_a sequences checked cycle by cycle
        step(1, 0, 0, '0, '0);
        step(0, 1, 0, 16'h0005, '0);
        for (int i = 0; i < 18; i++) step(0, 0, 0, '0, '0);

        // Both held high: round-robin order and 18-cycle spacing
        step(1, 0, 0, '0, '0);
        own_q.delete(); res_q.delete(); rv_q.delete();
        rec = 1'b1;
        for (int i = 0; i < 56; i++) step(0, 1, 1, 16'h0001, 16'h0000);
        rec = 1'b0;
        chk("rr_count", 32'(own_q.size()), 32'(3));
        if (own_q.size() == 3) begin
            chk("rr_own0", 32'(own_q[0]), 32'(0));
            chk("rr_own1", 32'(own_q[1]), 32'(1));
            chk("rr_own2", 32'(own_q[2]), 32'(0));
            chk("rr_res0", 32'(res_q[0]), 32'(1));
            chk("rr_res1", 32'(res_q[1]), 32'(0));
            chk("rr_res2", 32'(res_q[2]), 32'(1));
            chk("rr_gap0", 32'(rv_q[1] - rv_q[0]), 32'(18));
            chk("rr_gap1", 32'(rv_q[2] - rv_q[1]), 32'(18));
        end

        // Reset in RUN cycle 8 aborts, then a clean operation
        step(1, 0, 0, '0, '0);
        step(0, 1, 0, 16'hFFFF, '0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        chk("abort_busy", 32'(busy), 32'(0));
        for (int i = 0; i < 20; i++) step(0, 0, 0, '0, '0);
        step(0, 1, 0, 16'h0400, '0);
        for (int i = 0; i < 18; i++) step(0, 0, 0, '0, '0);

        // req1 pulse while requester 0 runs is never granted
        step(0, 1, 0, 16'h0000, '0);
        for (int i = 0; i < 18; i++) step(0, 0, (i == 4), '0, 16'hFFFF);
        step(0, 0, 0, '0, '0);

        // Random traffic with occasional resets
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 rand_word(), rand_word());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/or_reduce_arbiter.md
OR_REDUCE_ARBITER -- requirements
Module: or_reduce_arbiter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, the bit width of each requester's operand word (WIDTH >= 2).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 req0  input  1  requester 0 asks for an OR-reduction of in0.
REQ-005 in0  input  WIDTH  requester 0 operand word.
REQ-006 req1  input  1  requester 1 asks for an OR-reduction of in1.
REQ-007 in1  input  WIDTH  requester 1 operand word.
REQ-008 gnt0, gnt1  output  1 each  requester 0/1 currently owns the shared OR gate.
REQ-009 ack0, ack1  output  1 each  one-cycle pulse: the owner's result is on result.
REQ-010 result  output  1  OR of all WIDTH bits of the owner's captured word; meaningful only while result_valid=1.
REQ-011 result_valid  output  1  high for exactly one cycle per completed operation.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 or_a, or_b  output  1 each  operands driven to the shared external 2-input OR gate.
REQ-014 or_out  input  1  combinational output of the shared OR gate, sampled in the same cycle.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE with req0 or req1 high: grant one requester, capture its word into a WIDTH-bit shift register, clear accumulator acc and counter cnt, go to RUN.
REQ-017 Arbitration SHALL be round-robin: a sole requester wins; with both high, the requester not served last wins.
REQ-018 In RUN, each cycle: or_a=acc, or_b=shift[0]; at the edge acc<=or_out, shift>>=1, cnt<=cnt+1 (LSB processed first).
REQ-019 RUN SHALL last exactly WIDTH cycles with no early exit; the edge ending cycle cnt==WIDTH-1 moves to DONE.
REQ-020 In DONE: result=acc, result_valid=1, and ack of the owner =1 for one cycle; last-served<=owner; the next state SHALL be IDLE.
REQ-021 Latency: for a grant at edge E, result_valid SHALL be high in the cycle after edge E+WIDTH; at most one operation completes per WIDTH+2 cycles.
REQ-022 gntN SHALL be high in RUN and DONE for the owner only; gnt0 and gnt1 SHALL never both be high.
REQ-023 In IDLE and DONE, or_a and or_b SHALL be 0.
REQ-024 The operand word SHALL be sampled only at the grant edge; in0/in1 changes afterwards SHALL not affect the result.
REQ-025 req changes in RUN/DONE SHALL be ignored: the current operation completes and still acks; a req that is low when IDLE is sampled is never granted.
REQ-026 ack0, ack1 and result_valid SHALL never be high outside DONE.

Reset
REQ-027 With reset high at an edge, the block SHALL enter IDLE, clear acc, cnt and the shift register, and set last-served=1, so requester 0 wins the first tie.
REQ-028 In the cycle after reset, all outputs (gnt0, gnt1, ack0, ack1, result, result_valid, busy, or_a, or_b) SHALL be 0.
REQ-029 Reset SHALL take priority over every transition.
REQ-030 Reset asserted during RUN or DONE SHALL abort the operation: no ack or result_valid is produced for it.

Verification
REQ-031 Reset, then req0=1 with in0=16'h0000 for one edge -> busy=1, gnt0=1 for 17 cycles; in cycle 17 result_valid=1, ack0=1, result=0, ack1=0.
REQ-032 Reset, then req1 with in1=16'h8000 -> result=1 and ack1=1 in the cycle after edge E+16, proving the MSB is reached.
REQ-033 Reset, then in0=16'h0005 and or_out driven by a behavioural OR -> in RUN, or_b sequence is 1,0,1,0,0,...; or_a sequence is 0,1,1,1,...
REQ-034 req0 and req1 held high continuously with in0=16'h0001 and in1=0 -> grant order 0,1,0; results 1,0,1; consecutive result_valid pulses 18 cycles apart.
REQ-035 Reset pulsed in RUN cycle 8 -> the next cycle has busy=0 and gnt0=0; no ack follows; a subsequent req0 completes normally with the full 16-cycle RUN.
REQ-036 req1 pulsed for one cycle while requester 0 is in RUN -> gnt1 is never asserted and ack1 stays 0.
